alu_issue: RTL and testbench

Execute-side issue stage for the RV32I integer ALU. It accepts a decoded-stage instruction word plus PC and register-file operand values through a valid/ready handshake, and turns OP, OP-IMM, LUI and AUIPC instructions into the ALU's native `funct7`/`funct3`/A/B operation encoding. It registers the result behind a two-entry skid buffer and presents it to the ALU/writeback path through a second valid/ready handshake. It sits between register read and the ALU.

---
 rtl/alu_issue.sv | 154 +++++++++++++++
 tb/tb_alu_issue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into the ALU funct7/funct3/A/B
// encoding and registers the result behind a two-entry (main + skid) buffer.
module alu_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1_val,
   input  logic [31:0] in_rs2_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_funct7,
   output logic [2:0]  out_funct3,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [4:0]  out_rd,
   output logic        out_illegal
);

   typedef enum logic [6:0] {
      OPC_OP    = 7'b0110011,
      OPC_IMM   = 7'b0010011,
      OPC_LUI   = 7'b0110111,
      OPC_AUIPC = 7'b0010111
   } opcode_e;

   typedef struct packed {
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        illegal;
   } op_t;

   logic [6:0] f7;
   logic [2:0] f3;
   logic       unused_rs1_idx;
   op_t        dec;

   assign f7             = in_instr[31:25];
   assign f3             = in_instr[14:12];
   assign unused_rs1_idx = ^in_instr[19:15];

   always_comb begin
      dec         = '0;
      dec.rd      = in_instr[11:7];
      dec.illegal = 1'b1;
      case (in_instr[6:0])
         OPC_OP: begin
            if (f7 == 7'b0000000 ||
                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
               dec.funct7  = f7;
               dec.funct3  = f3;
               dec.a       = in_rs1_val;
               dec.b       = in_rs2_val;
               dec.illegal = 1'b0;
            end
         end
         OPC_IMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               if (f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000)) begin
                  dec.funct7  = f7;
                  dec.funct3  = f3;
                  dec.a       = in_rs1_val;
                  dec.b       = {27'b0, in_instr[24:20]};
                  dec.illegal = 1'b0;
               end
            end else begin
               // funct7 stays zero so immediate bit 30 cannot select subtract
               dec.funct3  = f3;
               dec.a       = in_rs1_val;
               dec.b       = {{20{in_instr[31]}}, in_instr[31:20]};
               dec.illegal = 1'b0;
            end
         end
         OPC_LUI: begin
            dec.b       = {in_instr[31:12], 12'b0};
            dec.illegal = 1'b0;
         end
         OPC_AUIPC: begin
            dec.a       = in_pc;
            dec.b       = {in_instr[31:12], 12'b0};
            dec.illegal = 1'b0;
         end
         default: ;
      endcase
   end

   op_t  main_q, main_d;
   op_t  skid_q, skid_d;
   logic main_valid_q, main_valid_d;
   logic skid_valid_q, skid_valid_d;
   logic in_ready_q, in_ready_d;
   logic in_xfer, out_xfer;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = main_valid_q & out_ready;

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || out_xfer) begin
         // main is free this cycle: skid (older) has precedence over the new op
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = in_xfer;
            if (in_xfer) skid_d = dec;
         end else begin
            main_valid_d = in_xfer;
            if (in_xfer) main_d = dec;
         end
      end else if (in_xfer) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_valid_q;
   assign out_funct7  = main_q.funct7;
   assign out_funct3  = main_q.funct3;
   assign out_a       = main_q.a;
   assign out_b       = main_q.b;
   assign out_rd      = main_q.rd;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cases plus random traffic against a
// queue-based reference of the decode rules and the two-deep FIFO behaviour.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val;
   logic        in_ready, out_valid, out_illegal;
   logic [6:0]  out_funct7;
   logic [2:0]  out_funct3;
   logic [31:0] out_a, out_b;
   logic [4:0]  out_rd;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_funct7(out_funct7), .out_funct3(out_funct3), .out_a(out_a), .out_b(out_b),
      .out_rd(out_rd), .out_illegal(out_illegal)
   );

   typedef struct {
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   bit   after_reset;
   bit   accepted;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t        r;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [31:0] imm_i, imm_u;
      bit          legal;
      op    = instr[6:0];
      f7    = instr[31:25];
      f3    = instr[14:12];
      imm_i = {{20{instr[31]}}, instr[31:20]};
      imm_u = instr & 32'hFFFF_F000;
      legal = 1'b0;
      r     = '{f7: 7'd0, f3: 3'd0, a: 32'd0, b: 32'd0, rd: instr[11:7], ill: 1'b0};
      if (op == 7'h33) begin
         legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         r.f7 = f7; r.f3 = f3; r.a = r1; r.b = r2;
      end else if (op == 7'h13) begin
         r.f3 = f3; r.a = r1;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
            r.f7 = f7;
            r.b  = 32'(instr[24:20]);
         end else begin
            legal = 1'b1;
            r.b   = imm_i;
         end
      end else if (op == 7'h37) begin
         legal = 1'b1; r.b = imm_u;
      end else if (op == 7'h17) begin
         legal = 1'b1; r.a = pc; r.b = imm_u;
      end
      if (!legal) r = '{f7: 7'd0, f3: 3'd0, a: 32'd0, b: 32'd0, rd: instr[11:7], ill: 1'b1};
      return r;
   endfunction

   task automatic check_outputs();
      check_val("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check_val("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         check_val("funct7", 32'(out_funct7), 32'(q[0].f7));
         check_val("funct3", 32'(out_funct3), 32'(q[0].f3));
         check_val("a", out_a, q[0].a);
         check_val("b", out_b, q[0].b);
         check_val("rd", 32'(out_rd), 32'(q[0].rd));
         check_val("illegal", 32'(out_illegal), 32'(q[0].ill));
      end
      if (after_reset) begin
         check_val("rst_data", {out_a ^ out_b}, 32'd0);
         check_val("rst_fields", {17'd0, out_funct7, out_funct3, out_rd}, 32'd0);
         check_val("rst_illegal", 32'(out_illegal), 32'd0);
      end
   endtask

   task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input bit ordy, input bit fl, input bit rs);
      bit ix, ox;
      @(negedge clk);
      check_outputs();
      in_valid = v; in_instr = instr; in_pc = pc; in_rs1_val = r1; in_rs2_val = r2;
      out_ready = ordy; flush = fl; rst = rs;
      ix = v && (q.size() < 2);
      ox = ordy && (q.size() > 0);
      accepted = 1'b0;
      @(posedge clk);
      after_reset = rs;
      if (rs) q.delete();
      else begin
         if (ox) void'(q.pop_front());
         if (fl) q.delete();
         else if (ix) begin
            q.push_back(ref_decode(instr, pc, r1, r2));
            accepted = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, 0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 5);
      case (k)
         0: begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 2))
               0: w[31:25] = 7'h00;
               1: w[31:25] = 7'h20;
               default: ;
            endcase
         end
         1, 2: begin
            w[6:0] = 7'h13;
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         end
         3: w[6:0] = 7'h37;
         4: w[6:0] = 7'h17;
         default: ;
      endcase
      return w;
   endfunction

   logic [31:0] ops [4];

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
      repeat (2) @(posedge clk);
      after_reset = 1'b1;
      q.delete();

      // ADDI x5, x1, -1
      step(1, 32'hFFF08293, 32'h0, 32'd5, 32'd0, 1, 0, 0);
      #1;
      check_val("addi_valid", 32'(out_valid), 32'd1);
      check_val("addi_f3f7", {22'd0, out_funct7, out_funct3}, 32'd0);
      check_val("addi_a", out_a, 32'd5);
      check_val("addi_b", out_b, 32'hFFFF_FFFF);
      check_val("addi_rd", 32'(out_rd), 32'd5);
      check_val("addi_ill", 32'(out_illegal), 32'd0);

      // SRAI then SLLI with funct7=0100000
      step(1, 32'h4030D093, 32'h0, 32'h8000_0000, 32'd0, 1, 0, 0);
      #1;
      check_val("srai_f3", 32'(out_funct3), 32'd5);
      check_val("srai_f7", 32'(out_funct7), 32'h20);
      check_val("srai_b", out_b, 32'd3);
      check_val("srai_a", out_a, 32'h8000_0000);
      step(1, 32'h40309093, 32'h0, 32'h1234_5678, 32'd0, 1, 0, 0);
      #1;
      check_val("slli_ill", 32'(out_illegal), 32'd1);
      check_val("slli_ab", out_a | out_b, 32'd0);
      check_val("slli_rd", 32'(out_rd), 32'd1);

      // LUI / AUIPC
      step(1, 32'h123452B7, 32'h0, 32'hDEAD_BEEF, 32'd0, 1, 0, 0);
      #1;
      check_val("lui_a", out_a, 32'd0);
      check_val("lui_b", out_b, 32'h1234_5000);
      step(1, 32'h12345297, 32'h100, 32'hDEAD_BEEF, 32'd0, 1, 0, 0);
      #1;
      check_val("auipc_a", out_a, 32'h100);
      check_val("auipc_b", out_b, 32'h1234_5000);
      idle(3);

      // Backpressure: four back-to-back ops
      ops[0] = 32'h002081B3; ops[1] = 32'h402081B3; ops[2] = 32'h8000C193; ops[3] = 32'h0FF0F193;
      step(1, ops[0], 32'h0, 32'd11, 32'd22, 0, 0, 0);
      step(1, ops[1], 32'h0, 32'd33, 32'd44, 1, 0, 0);
      step(1, ops[2], 32'h0, 32'd55, 32'd66, 0, 0, 0);
      #1;
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      step(1, ops[3], 32'h0, 32'd77, 32'd88, 0, 0, 0);
      check_val("bp_hold", 32'(accepted), 32'd0);
      for (int i = 0; i < 5 && !accepted; i++) step(1, ops[3], 32'h0, 32'd77, 32'd88, 1, 0, 0);
      check_val("bp_accept", 32'(accepted), 32'd1);
      idle(4);

      // Flush with both entries full and a valid input present
      step(1, ops[0], 32'h0, 32'd1, 32'd2, 0, 0, 0);
      step(1, ops[1], 32'h0, 32'd3, 32'd4, 0, 0, 0);
      step(1, ops[2], 32'h0, 32'd5, 32'd6, 0, 1, 0);
      #1;
      check_val("flush_valid", 32'(out_valid), 32'd0);
      check_val("flush_ready", 32'(in_ready), 32'd1);
      idle(3);

      // Reset with both entries full
      step(1, ops[0], 32'h0, 32'd9, 32'd9, 0, 0, 0);
      step(1, ops[3], 32'h0, 32'd9, 32'd9, 0, 0, 0);
      step(1, ops[1], 32'h0, 32'd9, 32'd9, 0, 0, 1);
      #1;
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_ready", 32'(in_ready), 32'd1);
      check_val("rst_ab", out_a | out_b, 32'd0);
      idle(2);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
      end
      idle(3);
      @(negedge clk);
      check_outputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
